// File: rtl/barrel_rotator.sv
// Registered left barrel rotator: log2(DATA_WIDTH) combinational mux stages
// followed by a single output register. Amounts wrap modulo DATA_WIDTH.
module barrel_rotator #(
  parameter int DATA_WIDTH = 32
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [DATA_WIDTH-1:0] data_in,
  input  logic [((($clog2(DATA_WIDTH) > 0) ? $clog2(DATA_WIDTH) : 1))-1:0] shift_amount,
  output logic [DATA_WIDTH-1:0] data_out
);

  localparam int SA_WIDTH = ($clog2(DATA_WIDTH) > 0) ? $clog2(DATA_WIDTH) : 1;

  // Fixed left rotate by a constant distance r (0 <= r < DATA_WIDTH).
  function automatic logic [DATA_WIDTH-1:0] rotl_const(
    input logic [DATA_WIDTH-1:0] x,
    input int                    r
  );
    logic [DATA_WIDTH-1:0] y;
    y = '0;
    for (int i = 0; i < DATA_WIDTH; i++) begin
      y[(i + r) % DATA_WIDTH] = x[i];
    end
    return y;
  endfunction

  logic [DATA_WIDTH-1:0] stage [0:SA_WIDTH];

  assign stage[0] = data_in;

  // Each stage rotates by 2^s reduced mod DATA_WIDTH. Rotations compose
  // additively mod DATA_WIDTH, so the chain yields a true modulo rotate even
  // for non-power-of-2 widths, with no divider in the path.
  for (genvar s = 0; s < SA_WIDTH; s++) begin : g_stage
    localparam int STEP = (1 << s) % DATA_WIDTH;
    assign stage[s+1] = shift_amount[s] ? rotl_const(stage[s], STEP) : stage[s];
  end

  // NOTE: sequential state uses non-blocking assignment so every flop samples
  // pre-edge values regardless of process ordering.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      data_out <= '0;
    end else begin
      data_out <= stage[SA_WIDTH];
    end
  end

endmodule

// File: tb/tb_barrel_rotator.sv
// Directed self-checking bench for barrel_rotator at widths 32, 24, 1, 8, 64.
module tb_barrel_rotator;

  logic clk;
  logic reset;

  logic [31:0] d32, q32;  logic [4:0] a32;
  logic [23:0] d24, q24;  logic [4:0] a24;
  logic [0:0]  d1,  q1;   logic [0:0] a1;
  logic [7:0]  d8,  q8;   logic [2:0] a8;
  logic [63:0] d64, q64;  logic [5:0] a64;

  int total;
  int bad;

  barrel_rotator #(.DATA_WIDTH(32)) u_w32 (.clk(clk), .reset(reset), .data_in(d32), .shift_amount(a32), .data_out(q32));
  barrel_rotator #(.DATA_WIDTH(24)) u_w24 (.clk(clk), .reset(reset), .data_in(d24), .shift_amount(a24), .data_out(q24));
  barrel_rotator #(.DATA_WIDTH(1))  u_w1  (.clk(clk), .reset(reset), .data_in(d1),  .shift_amount(a1),  .data_out(q1));
  barrel_rotator #(.DATA_WIDTH(8))  u_w8  (.clk(clk), .reset(reset), .data_in(d8),  .shift_amount(a8),  .data_out(q8));
  barrel_rotator #(.DATA_WIDTH(64)) u_w64 (.clk(clk), .reset(reset), .data_in(d64), .shift_amount(a64), .data_out(q64));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%h expected=%h", tag, got, exp);
    end
  endtask

  // Advance to just after the next rising edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Behavioural reference for the random runs at W=64.
  function automatic logic [63:0] ref_rotl64(input logic [63:0] x, input int amt);
    int k;
    k = amt % 64;
    return (x << k) | (x >> (64 - k));
  endfunction

  // 32-bit reference for the back-to-back sweep.
  function automatic logic [31:0] ref_rotl32(input logic [31:0] x, input int amt);
    int k;
    k = amt % 32;
    return (x << k) | (x >> (32 - k));
  endfunction

  initial begin
    #200000;
    $display("FAIL watchdog: got=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    logic [63:0] rnd_d;
    int          rnd_a;
    total = 0;
    bad   = 0;
    reset = 1'b1;
    d32 = '0; a32 = '0; d24 = '0; a24 = '0; d1 = '0; a1 = '0;
    d8  = '0; a8  = '0; d64 = '0; a64 = '0;

    #1;
    check("reset_w32", q32, 64'h0);
    check("reset_w64", q64, 64'h0);
    #13;
    reset = 1'b0;

    // Load a known value, then reset asynchronously mid-cycle.
    d32 = 32'hDEADBEEF; a32 = 5'd0;
    tick();
    check("preload", q32, 64'hDEADBEEF);
    #2 reset = 1'b1;
    #1 check("async_reset", q32, 64'h0);
    tick();
    check("reset_hold", q32, 64'h0);
    #2 reset = 1'b0;
    d32 = 32'h1; a32 = 5'd0;
    tick();
    check("first_after_reset", q32, 64'h1);

    // Identity, unit shift and maximum amount at W=32.
    d32 = 32'h80000001; a32 = 5'd0;  tick(); check("w32_amt0",  q32, 64'h80000001);
    d32 = 32'h80000001; a32 = 5'd1;  tick(); check("w32_amt1",  q32, 64'h00000003);
    d32 = 32'h00000001; a32 = 5'd31; tick(); check("w32_amt31", q32, 64'h80000000);
    d32 = 32'hF000000F; a32 = 5'd4;  tick(); check("w32_amt4",  q32, 64'h000000FF);

    // Input change between edges must not reach the output early.
    #2 d32 = 32'hFFFF0000;
    #1 check("w32_hold", q32, 64'h000000FF);
    a32 = 5'd16;
    tick();
    check("w32_amt16", q32, 64'h0000FFFF);

    // Back-to-back sweep, one new word per cycle.
    for (int k = 0; k < 32; k++) begin
      d32 = 32'h12345678;
      a32 = 5'(k);
      tick();
      check($sformatf("w32_sweep%0d", k), q32, 64'(ref_rotl32(32'h12345678, k)));
    end

    // Non-power-of-2 width: amounts wrap modulo 24.
    d24 = 24'h000001; a24 = 5'd30; tick(); check("w24_amt30", q24, 64'h000040);
    d24 = 24'h000001; a24 = 5'd23; tick(); check("w24_amt23", q24, 64'h800000);
    d24 = 24'h000001; a24 = 5'd24; tick(); check("w24_amt24", q24, 64'h000001);
    d24 = 24'hC00003; a24 = 5'd31; tick(); check("w24_amt31", q24, 64'h0001E0);
    d24 = 24'h123456; a24 = 5'd12; tick(); check("w24_amt12", q24, 64'h456123);

    // Degenerate width 1: amount ignored, data passes one cycle late.
    a1 = 1'b1;
    d1 = 1'b1; tick(); check("w1_one",  q1, 64'h1);
    d1 = 1'b0; tick(); check("w1_zero", q1, 64'h0);
    d1 = 1'b1; tick(); check("w1_one2", q1, 64'h1);

    // W=8 hand vectors.
    d8 = 8'h81; a8 = 3'd1; tick(); check("w8_amt1", q8, 64'h03);
    d8 = 8'h96; a8 = 3'd4; tick(); check("w8_amt4", q8, 64'h69);
    d8 = 8'h01; a8 = 3'd7; tick(); check("w8_amt7", q8, 64'h80);
    d8 = 8'hB4; a8 = 3'd3; tick(); check("w8_amt3", q8, 64'hA5);

    // W=64 hand vectors, then short random regression.
    d64 = 64'h8000000000000001; a64 = 6'd1;  tick(); check("w64_amt1",  q64, 64'h0000000000000003);
    d64 = 64'h0000000000000001; a64 = 6'd63; tick(); check("w64_amt63", q64, 64'h8000000000000000);
    d64 = 64'h0123456789ABCDEF; a64 = 6'd32; tick(); check("w64_amt32", q64, 64'h89ABCDEF01234567);
    for (int n = 0; n < 16; n++) begin
      rnd_d = {$urandom(), $urandom()};
      rnd_a = int'($urandom_range(0, 63));
      d64 = rnd_d;
      a64 = 6'(rnd_a);
      tick();
      check($sformatf("w64_rand%0d", n), q64, ref_rotl64(rnd_d, rnd_a));
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
